// File: rtl/conv_pkg.sv
// Shared types and constants for the ByteDecode coefficient path.
package conv_pkg;

  typedef logic [7:0] byte_t;

  localparam int N_COEFFS = 256;
  localparam int Q        = 3329;
  localparam int D_MAX    = 12;

  typedef enum logic [1:0] {
    BD_IDLE,
    BD_RUN,
    BD_DONE
  } bd_state_e;

endpackage

// File: rtl/bytes2bits.sv
// Flattens a packed byte array into a bit vector, byte i landing at bits [8i+:8].
module bytes2bits #(
  parameter int N_BYTES = 4
) (
  input  conv_pkg::byte_t [N_BYTES-1:0] i_bytes,
  output logic [8*N_BYTES-1:0]          o_bits
);

  always_comb begin
    o_bits = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      o_bits[8*i +: 8] = i_bytes[i];
    end
  end

endmodule

// File: rtl/byte_decode_seq.sv
// ByteDecode_d sequencer: flattens byte beats into an LSB-first bit buffer and pops d-bit coefficients.
// Define BYTE_DECODE_MODQ_EN to reduce 12-bit fields >= Q by Q on the output.
module byte_decode_seq #(
  parameter int N_BYTES  = 4,
  parameter int D_MAX    = conv_pkg::D_MAX,
  parameter int N_COEFFS = conv_pkg::N_COEFFS
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [3:0]             d_i,
  input  logic                   in_valid_i,
  input  logic [8*N_BYTES-1:0]   in_data_i,
  output logic                   in_ready_o,
  output logic                   coeff_valid_o,
  output logic [D_MAX-1:0]       coeff_o,
  output logic                   coeff_last_o,
  input  logic                   coeff_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  import conv_pkg::*;

  localparam int BEAT_W = 8 * N_BYTES;
  localparam int BUF_W  = BEAT_W + D_MAX - 1;
  localparam int FW     = $clog2(BUF_W + 1);
  localparam int BL_W   = $clog2((N_COEFFS / 8) * D_MAX / N_BYTES + 1);
  localparam int CW     = $clog2(N_COEFFS);

  bd_state_e          r_state, w_stateNext;
  logic [BUF_W-1:0]   r_bitBuf;
  logic [FW-1:0]      r_fill;
  logic [3:0]         r_d;
  logic [BL_W-1:0]    r_beatsLeft;
  logic [CW-1:0]      r_cnt;
  logic               r_err;

  logic [BEAT_W-1:0]  w_flat;
  logic [BUF_W-1:0]   w_flatExt, w_bufShifted, w_bufNext;
  logic [FW-1:0]      w_fillBase, w_fillNext;
  logic [D_MAX-1:0]   w_field;
  logic               w_legal, w_accept, w_push, w_pop;

  bytes2bits #(.N_BYTES(N_BYTES)) u_bytes2bits (
    .i_bytes (in_data_i),
    .o_bits  (w_flat)
  );

  assign w_legal   = (d_i != 4'd0) && (int'(d_i) <= D_MAX);
  assign w_accept  = (r_state == BD_IDLE) && start_i && w_legal;
  assign w_push    = in_valid_i && in_ready_o;
  assign w_pop     = coeff_valid_o && coeff_ready_i;
  assign w_flatExt = {{(BUF_W - BEAT_W){1'b0}}, w_flat};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= BD_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      BD_IDLE: if (w_accept) w_stateNext = BD_RUN;
      BD_RUN:  if (w_pop && coeff_last_o) w_stateNext = BD_DONE;
      BD_DONE: w_stateNext = BD_IDLE;
      default: w_stateNext = BD_IDLE;
    endcase
  end

  // Readiness looks at the current fill only, so it never depends on coeff_ready_i.
  always_comb begin
    busy_o        = (r_state == BD_RUN);
    done_o        = (r_state == BD_DONE);
    err_o         = r_err;
    in_ready_o    = (r_state == BD_RUN) && (r_beatsLeft != '0) &&
                    (int'(r_fill) + BEAT_W <= BUF_W);
    coeff_valid_o = (r_state == BD_RUN) && (r_fill >= FW'(r_d));
    coeff_last_o  = coeff_valid_o && (r_cnt == CW'(N_COEFFS - 1));
  end

  always_comb begin
    w_field = '0;
    for (int i = 0; i < D_MAX; i++) begin
      w_field[i] = (i < int'(r_d)) ? r_bitBuf[i] : 1'b0;
    end
`ifdef BYTE_DECODE_MODQ_EN
    coeff_o = w_field;
    if ((r_d == 4'd12) && (w_field >= D_MAX'(Q))) coeff_o = w_field - D_MAX'(Q);
`else
    coeff_o = w_field;
`endif
  end

  always_comb begin
    w_bufShifted = w_pop ? (r_bitBuf >> r_d) : r_bitBuf;
    w_fillBase   = w_pop ? (r_fill - FW'(r_d)) : r_fill;
    w_bufNext    = w_bufShifted;
    w_fillNext   = w_fillBase;
    if (w_push) begin
      w_bufNext  = w_bufShifted | (w_flatExt << w_fillBase);
      w_fillNext = w_fillBase + FW'(BEAT_W);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bitBuf    <= '0;
      r_fill      <= '0;
      r_d         <= '0;
      r_beatsLeft <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= (r_state == BD_IDLE) && start_i && !w_legal;
      if (w_accept) begin
        r_d         <= d_i;
        r_beatsLeft <= BL_W'((N_COEFFS / 8) * int'(d_i) / N_BYTES);
        r_cnt       <= '0;
        r_fill      <= '0;
        r_bitBuf    <= '0;
      end else if (r_state == BD_RUN) begin
        r_bitBuf <= w_bufNext;
        r_fill   <= w_fillNext;
        if (w_push) r_beatsLeft <= r_beatsLeft - BL_W'(1);
        if (w_pop)  r_cnt       <= r_cnt + CW'(1);
      end
    end
  end

endmodule
